// File: rtl/multicycle_contr.sv
// Multi-cycle MIPS control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory with a
// req/ack handshake and drives the datapath muxes, write enables and ALU control.
// Optional feature macro: CONTR_MULDIV_EN (mult/div busy state plus mfhi/mflo write-back).
// While rst is high every enable and mux select is forced to zero, so an access that
// is in flight when reset arrives can never complete a write.
module multicycle_contr #(
  parameter int unsigned ALU_W     = 4,
  parameter int unsigned PCSEL_W   = 3,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op_c,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord_c,
  output logic               ir_we,
  output logic               pc_we,
  output logic [PCSEL_W-1:0] pc_next_c,
  output logic               we_c,
  output logic [1:0]         dest_reg_c,
  output logic [2:0]         result_c,
  output logic               argA_c,
  output logic [1:0]         argB_c,
  output logic [1:0]         ext_c,
  output logic [ALU_W-1:0]   alu_c,
  output logic               busy,
  output logic               illegal_op
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StRtype, StExeci, StWbr, StWbi, StMemaddr, StMemrd,
    StMemwr, StMemwb, StBranch, StJump, StJal, StJumpr, StIllegal, StMuldiv
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnJr    = 6'b001000;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnSubu  = 6'b100011;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnXor   = 6'b100110;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSltu  = 6'b101011;
`ifdef CONTR_MULDIV_EN
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
`endif

  localparam logic [ALU_W-1:0] AluAnd  = ALU_W'(4'b0000);
  localparam logic [ALU_W-1:0] AluOr   = ALU_W'(4'b0001);
  localparam logic [ALU_W-1:0] AluAdd  = ALU_W'(4'b0010);
  localparam logic [ALU_W-1:0] AluXor  = ALU_W'(4'b0011);
  localparam logic [ALU_W-1:0] AluSub  = ALU_W'(4'b0110);
  localparam logic [ALU_W-1:0] AluSlt  = ALU_W'(4'b0111);
  localparam logic [ALU_W-1:0] AluSltu = ALU_W'(4'b1000);
  localparam logic [ALU_W-1:0] AluNor  = ALU_W'(4'b1100);

  // One-hot {jr, j, branch}; all-zero selects pc+4.
  localparam logic [PCSEL_W-1:0] PcBranch = PCSEL_W'(3'b001);
  localparam logic [PCSEL_W-1:0] PcJump   = PCSEL_W'(3'b010);
  localparam logic [PCSEL_W-1:0] PcJr     = PCSEL_W'(3'b100);

  state_e state_q, state_d;

  logic             f_legal;
  logic             f_jr;
  logic [ALU_W-1:0] f_alu;

`ifdef CONTR_MULDIV_EN
  localparam int unsigned MdW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  logic           f_md;
  logic           f_mfhi;
  logic           f_mflo;
  logic [MdW-1:0] md_cnt_q, md_cnt_d;
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CONTR_MULDIV_EN
  // Mult/div busy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end
`endif

  // R-type funct decode: legality, ALU op and special classes.
  always_comb begin
    f_legal = 1'b1;
    f_jr    = 1'b0;
    f_alu   = AluAdd;
`ifdef CONTR_MULDIV_EN
    f_md    = 1'b0;
    f_mfhi  = 1'b0;
    f_mflo  = 1'b0;
`endif
    case (funct)
      FnAdd, FnAddu: f_alu = AluAdd;
      FnSub, FnSubu: f_alu = AluSub;
      FnAnd:         f_alu = AluAnd;
      FnOr:          f_alu = AluOr;
      FnXor:         f_alu = AluXor;
      FnNor:         f_alu = AluNor;
      FnSlt:         f_alu = AluSlt;
      FnSltu:        f_alu = AluSltu;
      FnJr:          f_jr  = 1'b1;
`ifdef CONTR_MULDIV_EN
      FnMult, FnMultu, FnDiv, FnDivu: f_md = 1'b1;
      FnMfhi:        f_mfhi = 1'b1;
      FnMflo:        f_mflo = 1'b1;
`endif
      default:       f_legal = 1'b0;
    endcase
  end

  // Next-state and Moore output decode; pc_we/ir_we qualified by mem_ack/zero.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord_c     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_next_c  = '0;
    we_c       = 1'b0;
    dest_reg_c = 2'b00;
    result_c   = 3'b000;
    argA_c     = 1'b0;
    argB_c     = 2'b00;
    ext_c      = 2'b00;
    alu_c      = '0;
    illegal_op = 1'b0;
    busy       = (state_q != StFetch);
`ifdef CONTR_MULDIV_EN
    md_cnt_d   = md_cnt_q;
`endif

    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        argB_c  = 2'b01;
        alu_c   = AluAdd;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Precompute the branch target into ALU-out.
        argB_c = 2'b11;
        alu_c  = AluAdd;
        case (op_c)
          OpRtype: begin
            if (!f_legal) begin
              state_d = StIllegal;
            end else if (f_jr) begin
              state_d = StJumpr;
`ifdef CONTR_MULDIV_EN
            end else if (f_md) begin
              state_d  = StMuldiv;
              md_cnt_d = MdW'(MD_CYCLES - 1);
`endif
            end else begin
              state_d = StRtype;
            end
          end
          OpLw, OpSw:                    state_d = StMemaddr;
          OpBeq, OpBne:                  state_d = StBranch;
          OpAddi, OpAndi, OpOri, OpLui:  state_d = StExeci;
          OpJ:                           state_d = StJump;
          OpJal:                         state_d = StJal;
          default:                       state_d = StIllegal;
        endcase
      end
      StRtype: begin
        argA_c  = 1'b1;
        argB_c  = 2'b00;
        alu_c   = f_alu;
        state_d = StWbr;
      end
      StExeci: begin
        argA_c = 1'b1;
        argB_c = 2'b10;
        case (op_c)
          OpAndi: begin
            ext_c = 2'b01;
            alu_c = AluAnd;
          end
          OpOri: begin
            ext_c = 2'b01;
            alu_c = AluOr;
          end
          // lui adds the shifted immediate to rs, which the encoding fixes at $0.
          OpLui: begin
            ext_c = 2'b10;
            alu_c = AluAdd;
          end
          default: begin
            ext_c = 2'b00;
            alu_c = AluAdd;
          end
        endcase
        state_d = StWbi;
      end
      StWbr: begin
        we_c       = 1'b1;
        dest_reg_c = 2'b01;
        result_c   = 3'b000;
`ifdef CONTR_MULDIV_EN
        if (f_mfhi) begin
          result_c = 3'b011;
        end else if (f_mflo) begin
          result_c = 3'b100;
        end
`endif
        state_d = StFetch;
      end
      StWbi: begin
        we_c       = 1'b1;
        dest_reg_c = 2'b00;
        result_c   = 3'b000;
        state_d    = StFetch;
      end
      StMemaddr: begin
        argA_c  = 1'b1;
        argB_c  = 2'b10;
        alu_c   = AluAdd;
        state_d = (op_c == OpSw) ? StMemwr : StMemrd;
      end
      StMemrd: begin
        mem_req = 1'b1;
        iord_c  = 1'b1;
        if (mem_ack) begin
          state_d = StMemwb;
        end
      end
      StMemwr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord_c  = 1'b1;
        if (mem_ack) begin
          state_d = StFetch;
        end
      end
      StMemwb: begin
        we_c       = 1'b1;
        dest_reg_c = 2'b00;
        result_c   = 3'b001;
        state_d    = StFetch;
      end
      StBranch: begin
        argA_c    = 1'b1;
        argB_c    = 2'b00;
        alu_c     = AluSub;
        pc_next_c = PcBranch;
        pc_we     = ((op_c == OpBeq) && zero) || ((op_c == OpBne) && !zero);
        state_d   = StFetch;
      end
      StJump: begin
        pc_we     = 1'b1;
        pc_next_c = PcJump;
        state_d   = StFetch;
      end
      StJal: begin
        pc_we      = 1'b1;
        pc_next_c  = PcJump;
        we_c       = 1'b1;
        dest_reg_c = 2'b10;
        result_c   = 3'b010;
        state_d    = StFetch;
      end
      StJumpr: begin
        pc_we     = 1'b1;
        pc_next_c = PcJr;
        state_d   = StFetch;
      end
      StIllegal: begin
        illegal_op = 1'b1;
        state_d    = StFetch;
      end
      StMuldiv: begin
`ifdef CONTR_MULDIV_EN
        argA_c = 1'b1;
        argB_c = 2'b00;
        if (md_cnt_q == '0) begin
          state_d = StFetch;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
`else
        state_d = StFetch;
`endif
      end
      default: state_d = StFetch;
    endcase

    // Reset squashes every enable and select in the same cycle.
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord_c     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_next_c  = '0;
      we_c       = 1'b0;
      dest_reg_c = 2'b00;
      result_c   = 3'b000;
      argA_c     = 1'b0;
      argB_c     = 2'b00;
      ext_c      = 2'b00;
      alu_c      = '0;
      illegal_op = 1'b0;
    end
  end

endmodule
